fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage sitting directly upstream of the program memory and feeding the IF/ID pipeline register. Each cycle it drives the 8-bit program-memory address and samples the combinational 32-bit instruction. It resolves `JMP` (call-style, pushes the return address), `RET` (pops it) and `HALT` itself, with zero bubbles. It presents a registered, valid-qualified instruction to decode.

## Interface
- `RAS_DEPTH`, 4: return-address stack entries (≥2, power of two).
- `RESET_PC`, 8'h00: PC loaded on reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  decode back-pressure; freezes the whole stage.
- `pm_addr`  out  8  program-memory address, combinational from PC.
- `pm_data`  in  32  program-memory word: bits [31:16] reserved, [15:12] opcode, [11:0] operand.
- `if_instr`  out  32  registered instruction to decode.
- `if_pc`  out  8  address of `if_instr`.
- `if_valid`  out  1  `if_instr` is a real instruction for decode.
- `halted`  out  1  sticky; set after `HALT` is issued.
- `stack_err`  out  1  sticky; return-stack overflow or underflow seen.

## Operation
- `pm_addr = pc` at all times, including while stalled or halted.
- Predecode `op = pm_data[15:12]` each active cycle (not `rst`, not `stall`, not `halted`):
  - `JMP`:
    - `pc <= pm_data[7:0]`; `pm_data[11:8]` ignored.
    - Push `pc+1` (mod 256).
    - `if_valid <= 0`.
  - `RET`, stack non-empty:
    - `pc <=` popped top.
    - `if_valid <= 0`.
  - `RET`, stack empty:
    - `stack_err <= 1`; treated as `HALT`.
    - `halted <= 1`, `if_valid <= 0`, `pc` holds.
  - `HALT`:
    - `if_instr <= pm_data`, `if_pc <= pc`, `if_valid <= 1` for exactly one cycle.
    - `halted <= 1`; `pc` holds.
  - Any other opcode:
    - `if_instr <= pm_data`, `if_pc <= pc`, `if_valid <= 1`.
    - `pc <= pc+1`, wrapping 255 → 0.
- `JMP` when stack is full:
  - Push dropped, stack unchanged.
  - `stack_err <= 1`.
  - Jump still taken.
- Halted:
  - `pc`, stack and outputs frozen.
  - `if_valid <= 0` from the cycle after the `HALT` issue.
  - Only `rst` exits.
- `stall=1`:
  - `pc`, stack pointer, stack contents, `if_instr`, `if_pc`, `if_valid`, `halted` and `stack_err` all hold.
  - Stall has priority over every opcode action.
- `rst` has priority over `stall`. It clears:
  - `pc=RESET_PC`, `sp=0`.
  - `if_instr=0`, `if_pc=0`, `if_valid=0`.
  - `halted=0`, `stack_err=0`.
  - Stack contents are don't-care.

## Timing
- Word at address A fetched while `pc=A`; it appears on `if_instr`/`if_pc` at the next edge.
- Fetch-to-output latency is 1 cycle.
- Taken `JMP`/`RET`:
  - Exactly one `if_valid=0` cycle, the slot of the control instruction itself.
  - Target instruction fetched the very next cycle; no extra bubble.
- Back-to-back `RET` (pop then pop), `JMP` directly into `RET`, and `JMP` to its own address are all legal at 1 instr/cycle.
- Stack pointer updates are registered. A push and the following cycle's pop must return the just-pushed value; there is no same-cycle push+pop.
- `stall` deasserting: the held `if_instr` is considered consumed on the first unstalled edge.

## Structure
- Opcode constants `JMP`, `RET`, `HALT`, `NOP` come from the shared ISA include (`isa.v`), together with field-position constants `OPC_MSB=15`, `OPC_LSB=12`, `JTGT_W=8`.
- Add `PC_W=8` to that include; `progmem` and decode share it.
- Sub-module `return_stack`:
  - Parameters: `DEPTH`, `W`.
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `dout` (top), `empty`, `full`.
  - Synchronous; no internal error handling.
- `fetch_unit` owns PC, output register, sticky flags and predecode.

## Test plan
- Reset then run the RET program (0:LOADC, 1:JMP 10, 2:LOADC, 3:JMP 7, 4:ADD, 5:STORE, 6:HALT, 7:LOAD, 8:LOAD, 9:RET, 10:LOADC, 11:RET):
  - Valid `if_pc` sequence 0,10,2,7,8,4,5,6.
  - `halted=1` after 6.
  - `stack_err=0`.
- Linear code 0..3 then `HALT`:
  - `if_pc` 0,1,2,3,4 on consecutive cycles.
  - `if_valid` low forever afterwards.
  - `pm_addr` stays 4.
- Nested `JMP` depth `RAS_DEPTH+1` (RAS_DEPTH=4):
  - Fifth push dropped and `stack_err=1`.
  - Subsequent four `RET`s return correctly.
  - Fifth `RET` halts.
- `RET` at address 0 after reset:
  - `stack_err=1`, `halted=1`.
  - `if_valid` never asserted.
- `stall` held 3 cycles mid-stream and while a `JMP` is on `pm_data`:
  - Outputs and `pm_addr` constant throughout.
  - No push occurs.
  - Sequence resumes unchanged.
- `rst` asserted the cycle after a `JMP` and also while halted:
  - `pc=0`, `if_valid=0`, flags cleared next cycle.
  - Stack behaves empty (an immediate `RET` sets `stack_err`).

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared ISA constants for the fetch stage and its neighbours.
// Opcode encodings, field positions and the program-counter width.
package fetch_unit_pkg;

  localparam int PC_W    = 8;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int JTGT_W  = 8;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_LOADC = 4'h4,
    OP_JMP   = 4'h8,
    OP_RET   = 4'h9,
    OP_HALT  = 4'hF
  } opcode_e;

  function automatic opcode_e opcode(
    input logic [31:0] w
  );
    return opcode_e'(w[OPC_MSB:OPC_LSB]);
  endfunction

endpackage

// File: rtl/fetch_unit_return_stack.sv
// Return-address stack: registered pointer, top of stack read
// combinationally. Callers gate push/pop against full/empty.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   sp_q;
  logic [AW:0]   sp_d;
  logic [AW-1:0] top_idx;

  assign top_idx = sp_q[AW-1:0] - 1'b1;
  assign dout    = mem_q[top_idx];
  assign empty   = (sp_q == '0);
  assign full    = (sp_q == (AW+1)'(DEPTH));

  always_comb begin
    sp_d = sp_q;
    if (push && !full) begin
      sp_d = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Contents need no reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      mem_q[sp_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, predecode of JMP/RET/HALT with no
// bubbles beyond the control slot, and the IF/ID output register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  output logic [PC_W-1:0] pm_addr,
  input  logic [31:0]     pm_data,
  output logic [31:0]     if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic            if_valid,
  output logic            halted,
  output logic            stack_err
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] ipc_q, ipc_d;
  logic            valid_q, valid_d;
  logic            halt_q, halt_d;
  logic            err_q, err_d;

  logic            ras_push, ras_pop;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty, ras_full;

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_q + 8'd1),
    .dout  (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    halt_d   = halt_q;
    err_d    = err_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (!stall) begin
      if (halt_q) begin
        valid_d = 1'b0;
      end else begin
        unique case (opcode(pm_data))
          OP_JMP: begin
            pc_d     = pm_data[JTGT_W-1:0];
            valid_d  = 1'b0;
            ras_push = !ras_full;
            if (ras_full) err_d = 1'b1;
          end
          OP_RET: begin
            valid_d = 1'b0;
            // Underflow is fatal: behave as HALT.
            if (ras_empty) begin
              err_d  = 1'b1;
              halt_d = 1'b1;
            end else begin
              pc_d    = ras_top;
              ras_pop = 1'b1;
            end
          end
          OP_HALT: begin
            instr_d = pm_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            halt_d  = 1'b1;
          end
          default: begin
            instr_d = pm_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 8'd1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  assign pm_addr   = pc_q;
  assign if_instr  = instr_q;
  assign if_pc     = ipc_q;
  assign if_valid  = valid_q;
  assign halted    = halt_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected issues are queued by the
// stimulus; a monitor pops and compares each consumed instruction.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [7:0]  pm_addr;
  logic [31:0] pm_data;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic        if_valid;
  logic        halted;
  logic        stack_err;

  logic [31:0] prog [256];
  exp_t        sb [$];
  int          errors = 0;
  int          checks = 0;

  assign pm_data = prog[pm_addr];

  always #5 clk = ~clk;

  fetch_unit #(
    .RAS_DEPTH (4),
    .RESET_PC  (8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .pm_addr   (pm_addr),
    .pm_data   (pm_data),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .if_valid  (if_valid),
    .halted    (halted),
    .stack_err (stack_err)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clr_prog();
    for (int i = 0; i < 256; i++)
      prog[i] = {8'hC3, 8'(i), 4'(OP_HALT), 12'h000};
  endtask

  task automatic set(input int a, input opcode_e op,
                     input logic [11:0] opnd);
    prog[a] = {8'hC3, 8'(a), 4'(op), opnd};
  endtask

  task automatic expect_pc(input int a);
    exp_t e;
    e.pc    = 8'(a);
    e.instr = prog[a];
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    chk("rst_pm_addr", {24'h0, pm_addr}, 32'h0);
    chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", {24'h0, if_pc}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_stack_err", {31'h0, stack_err}, 32'h0);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input logic [7:0] a, input int budget);
    int n = 0;
    while (!(if_valid && if_pc == a) && n < budget) begin
      cyc(1);
      n++;
    end
    chk("wait_valid_pc", {31'h0, if_valid && if_pc == a}, 32'h1);
  endtask

  task automatic drained(input string name);
    chk(name, sb.size(), 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst && !stall && if_valid) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: got pc=%0d want none",
                     if_pc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (if_pc !== e.pc || if_instr !== e.instr) begin
              errors++;
              $display("FAIL issue: got pc=%0d %h want pc=%0d %h",
                       if_pc, if_instr, e.pc, e.instr);
            end
          end
        end
      end
      begin
        logic [31:0] s_instr;
        logic [7:0]  s_pc;
        logic [7:0]  s_addr;
        cyc(1);

        // Call/return program.
        clr_prog();
        set(0, OP_LOADC, 12'h011); set(1, OP_JMP, 12'hF0A);
        set(2, OP_LOADC, 12'h022); set(3, OP_JMP, 12'h007);
        set(4, OP_ADD, 12'h000);   set(5, OP_STORE, 12'h005);
        set(6, OP_HALT, 12'h000);  set(7, OP_LOAD, 12'h007);
        set(8, OP_LOAD, 12'h008);  set(9, OP_RET, 12'h000);
        set(10, OP_LOADC, 12'h0AA); set(11, OP_RET, 12'h000);
        foreach (sb[i]) ;
        expect_pc(0); expect_pc(10); expect_pc(2); expect_pc(7);
        expect_pc(8); expect_pc(4); expect_pc(5); expect_pc(6);
        do_reset();
        cyc(25);
        chk("ret_halted", {31'h0, halted}, 32'h1);
        chk("ret_err", {31'h0, stack_err}, 32'h0);
        chk("ret_pm_addr", {24'h0, pm_addr}, 32'd6);
        drained("ret_drained");

        // Linear code then HALT.
        clr_prog();
        set(0, OP_NOP, 12'h000); set(1, OP_LOAD, 12'h001);
        set(2, OP_ADD, 12'h002); set(3, OP_STORE, 12'h003);
        set(4, OP_HALT, 12'h004);
        for (int i = 0; i < 5; i++) expect_pc(i);
        do_reset();
        for (int i = 0; i < 5; i++) begin
          cyc(1);
          chk("lin_pc", {24'h0, if_pc}, 32'(i));
          chk("lin_valid", {31'h0, if_valid}, 32'h1);
        end
        cyc(10);
        chk("lin_valid_low", {31'h0, if_valid}, 32'h0);
        chk("lin_pm_addr", {24'h0, pm_addr}, 32'd4);
        chk("lin_halted", {31'h0, halted}, 32'h1);
        drained("lin_drained");

        // Nested calls one deeper than the stack.
        clr_prog();
        set(0, OP_JMP, 12'h00A);
        set(10, OP_LOADC, 12'h0); set(11, OP_JMP, 12'd20);
        set(20, OP_LOADC, 12'h0); set(21, OP_JMP, 12'd30);
        set(30, OP_LOADC, 12'h0); set(31, OP_JMP, 12'd40);
        set(40, OP_LOADC, 12'h0); set(41, OP_JMP, 12'd50);
        set(50, OP_LOADC, 12'h0); set(51, OP_RET, 12'h0);
        set(32, OP_LOADC, 12'h0); set(33, OP_RET, 12'h0);
        set(22, OP_LOADC, 12'h0); set(23, OP_RET, 12'h0);
        set(12, OP_LOADC, 12'h0); set(13, OP_RET, 12'h0);
        set(1, OP_LOADC, 12'h0);  set(2, OP_RET, 12'h0);
        expect_pc(10); expect_pc(20); expect_pc(30);
        expect_pc(40); expect_pc(50); expect_pc(32);
        expect_pc(22); expect_pc(12); expect_pc(1);
        do_reset();
        wait_valid(8'd40, 30);
        chk("nest_err_pre", {31'h0, stack_err}, 32'h0);
        cyc(1);
        chk("nest_err_post", {31'h0, stack_err}, 32'h1);
        chk("nest_pm_addr", {24'h0, pm_addr}, 32'd50);
        cyc(20);
        chk("nest_halted", {31'h0, halted}, 32'h1);
        chk("nest_err", {31'h0, stack_err}, 32'h1);
        chk("nest_pm_end", {24'h0, pm_addr}, 32'd2);
        drained("nest_drained");

        // RET as the very first instruction.
        clr_prog();
        set(0, OP_RET, 12'h0);
        do_reset();
        cyc(8);
        chk("ret0_err", {31'h0, stack_err}, 32'h1);
        chk("ret0_halted", {31'h0, halted}, 32'h1);
        chk("ret0_pm_addr", {24'h0, pm_addr}, 32'd0);
        drained("ret0_drained");

        // Stall mid-stream and with a JMP on pm_data.
        clr_prog();
        set(0, OP_LOADC, 12'h050); set(1, OP_ADD, 12'h001);
        set(2, OP_JMP, 12'h008);   set(8, OP_LOAD, 12'h008);
        set(9, OP_RET, 12'h0);     set(3, OP_LOADC, 12'h033);
        set(4, OP_RET, 12'h0);
        expect_pc(0); expect_pc(1); expect_pc(8); expect_pc(3);
        do_reset();
        for (int k = 0; k < 2; k++) begin
          cyc(1);
          stall = 1'b1;
          s_instr = if_instr;
          s_pc    = if_pc;
          s_addr  = pm_addr;
          chk("stl_addr0", {24'h0, s_addr}, 32'(k + 1));
          for (int j = 0; j < 3; j++) begin
            cyc(1);
            chk("stl_instr", if_instr, s_instr);
            chk("stl_pc", {24'h0, if_pc}, {24'h0, s_pc});
            chk("stl_valid", {31'h0, if_valid}, 32'h1);
            chk("stl_addr", {24'h0, pm_addr}, {24'h0, s_addr});
          end
          stall = 1'b0;
        end
        cyc(15);
        chk("stl_err", {31'h0, stack_err}, 32'h1);
        chk("stl_halted", {31'h0, halted}, 32'h1);
        drained("stl_drained");

        // Reset right after a JMP, then again while halted.
        clr_prog();
        set(0, OP_LOADC, 12'h0); set(1, OP_JMP, 12'h005);
        set(5, OP_LOADC, 12'h0);
        expect_pc(0);
        do_reset();
        cyc(2);
        chk("rj_pm_addr", {24'h0, pm_addr}, 32'd5);
        set(0, OP_RET, 12'h0);
        do_reset();
        cyc(5);
        chk("rj_err", {31'h0, stack_err}, 32'h1);
        chk("rj_halted", {31'h0, halted}, 32'h1);
        do_reset();
        cyc(5);
        chk("rh_err", {31'h0, stack_err}, 32'h1);
        chk("rh_halted", {31'h0, halted}, 32'h1);
        drained("rst_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    join
  end

endmodule
